// File: rtl/bcd_pkg.sv
// Shared types and constants for the binary-to-BCD converter.
// Holds the FSM state enum, the add-3 threshold and a digit-count helper.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } conv_state_t;

    localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;

    // Smallest D with 10^D >= 2^w, i.e. ceil(w*log10(2)).
    // 2^w is never a power of ten, so this is floor(w*log10(2)) + 1.
    function automatic int min_digits(input int w);
        longint prod;
        prod = longint'(w) * 64'sd30103;
        return int'(prod / 64'sd100000) + 1;
    endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// Combinational double-dabble nibble correction: adds 3 when digit >= 5.
// Ports: digit (4-bit BCD in), adjusted (4-bit corrected out).
module bcd_digit_adjust
    import bcd_pkg::*;
(
    input  logic [3:0] digit,
    output logic [3:0] adjusted
);

    always_comb begin
        adjusted = digit;
        if (digit >= BCD_ADJ_THRESH) begin
            adjusted = digit + 4'd3;
        end
    end

endmodule

// File: rtl/bin_to_bcd_converter.sv
// Sequential shift-and-add-3 binary-to-BCD converter, one bit per clock.
// Ports: clock, reset (sync, active-high), start, bin[WIDTH] in;
//        busy, done (1-cycle pulse), bcd[4*DIGITS], blank[DIGITS] out.
module bin_to_bcd_converter
    import bcd_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
)
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [DIGITS-1:0]     blank
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int SR_W  = BCD_W + WIDTH;
    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(WIDTH - 1);
    // All digits blanked except the units digit.
    localparam logic [DIGITS-1:0] BLANK_ZERO = ~DIGITS'(1);

    if (WIDTH < 1) begin : g_bad_width
        $error("bin_to_bcd_converter: WIDTH must be at least 1");
    end

    if (DIGITS < min_digits(WIDTH)) begin : g_bad_digits
        $error("bin_to_bcd_converter: DIGITS too small for WIDTH");
    end

    conv_state_t        state;
    conv_state_t        state_next;
    logic [SR_W-1:0]    sr;
    logic [SR_W-1:0]    sr_next;
    logic [SR_W-1:0]    sr_adj;
    logic [SR_W-1:0]    sr_shift;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_next;
    logic [BCD_W-1:0]   bcd_final;
    logic [DIGITS-1:0]  blank_next;
    logic               load_out;
    logic               zero_run;

    // Unconsumed binary bits pass through untouched; only the
    // BCD nibbles above them receive the add-3 correction.
    assign sr_adj[WIDTH-1:0] = sr[WIDTH-1:0];

    for (genvar i = 0; i < DIGITS; i++) begin : g_adj
        bcd_digit_adjust u_adj (
            .digit    (sr[WIDTH + 4*i +: 4]),
            .adjusted (sr_adj[WIDTH + 4*i +: 4])
        );
    end

    assign sr_shift  = sr_adj << 1;
    assign bcd_final = sr_shift[SR_W-1:WIDTH];

    // Blank bit i marks digit i and every higher digit as zero.
    always_comb begin
        blank_next = '0;
        zero_run   = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_run      = zero_run & (bcd_final[4*i +: 4] == 4'd0);
            blank_next[i] = zero_run;
        end
    end

    always_comb begin
        state_next = state;
        sr_next    = sr;
        cnt_next   = cnt;
        load_out   = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    sr_next    = {{BCD_W{1'b0}}, bin};
                    cnt_next   = '0;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                sr_next  = sr_shift;
                cnt_next = cnt + CNT_W'(1);
                if (cnt == LAST_SHIFT) begin
                    state_next = DONE;
                    load_out   = 1'b1;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            sr    <= '0;
            cnt   <= '0;
            bcd   <= '0;
            blank <= BLANK_ZERO;
        end else begin
            state <= state_next;
            sr    <= sr_next;
            cnt   <= cnt_next;
            if (load_out) begin
                bcd   <= bcd_final;
                blank <= blank_next;
            end
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule

// File: doc/bin_to_bcd_converter.md
# bin_to_bcd_converter

Sequential binary-to-BCD converter using shift-and-add-3 (double dabble), one bit per clock. It takes an unsigned binary value and produces packed BCD digits plus a leading-zero blank mask. It sits directly upstream of the per-digit BCD-to-seven-segment decoders: each 4-bit output nibble feeds one decoder, and each blank bit gates that display.

## Interface

- `WIDTH`, default 16: binary input width; must be ≥ 1.
- `DIGITS`, default 5: number of BCD output digits; must satisfy 10^DIGITS ≥ 2^WIDTH (elaboration-time assertion).
- `clock`  input  1  sole clock; all state updates on its rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `start`  input  1  request a conversion of `bin`; sampled only in IDLE.
- `bin`  input  WIDTH  unsigned value; sampled on the accepting edge only.
- `busy`  output  1  high in SHIFT and DONE.
- `done`  output  1  one-cycle pulse; `bcd`/`blank` updated the same cycle.
- `bcd`  output  4*DIGITS  packed digits; digit i is `bcd[4i+3:4i]`, digit 0 least significant.
- `blank`  output  DIGITS  bit i high when digit i is a leading zero; bit 0 is always 0.

## Operation

- Reset state and outputs: state IDLE, `busy`=0, `done`=0, `bcd`=0, `blank`={DIGITS-1 ones, 0}. This applies regardless of the current state, so reset mid-conversion abandons the conversion and emits no `done`.
- States:
  - IDLE: if `start`=1, load shift register with {4*DIGITS zeros, `bin`}, clear the bit counter, and go to SHIFT. Otherwise stay.
  - SHIFT: each cycle, first add 3 to every BCD nibble ≥ 5, then shift the whole register left by 1 and increment the counter. After the WIDTH-th shift, go to DONE.
  - DONE: `done`=1 for exactly this cycle. Return to IDLE on the next edge unconditionally.
- `bcd` and `blank` are output registers, written only on the edge entering DONE. They hold their value until the next completed conversion or reset, so the display never shows intermediate values.
- `blank` computation: bit i is 1 iff digit i and all higher digits are zero, for i ≥ 1. Value 0 yields blank = {DIGITS-1 ones, 0}.
- `start` in SHIFT or DONE is ignored: no queueing, no restart. `bin` changes after the accepting edge have no effect.
- Add-3 is applied only to BCD nibbles, never to the unconsumed binary bits. No nibble ever exceeds 9 after a shift.
- Counter width is $clog2(WIDTH+1). The counter must not wrap before WIDTH shifts.

## Timing

- `start` sampled high in IDLE at edge t:
  - SHIFT occupies edges t+1 … t+WIDTH.
  - DONE is entered at edge t+WIDTH, with `done`=1 in the cycle following that edge.
  - IDLE is re-entered at edge t+WIDTH+1.
- Latency: WIDTH cycles from the accepting edge to `done` (16 at defaults).
- Throughput: with `start` held high, one conversion is accepted every WIDTH+2 cycles (18 at defaults). The next accept occurs at edge t+WIDTH+2, the first edge seen in IDLE.
- `busy` rises the cycle after the accepting edge and falls the cycle after `done`.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure

- Package `bcd_pkg`:
  - state enum `conv_state_t` {IDLE, SHIFT, DONE}.
  - constant `BCD_ADJ_THRESH` = 4'd5.
  - localparam helper to compute the minimum digit count, used in the DIGITS assertion.
- Sub-module `bcd_digit_adjust`: combinational, 4-bit in/out, adds 3 when input ≥ 5. Instantiated DIGITS times via a generate loop.
- Top level holds the FSM, bit counter, shift register, output registers and blank logic.

## Test plan

- After reset with no `start`: `bcd`=0x00000, `blank`=5'b11110, `busy`=0, `done`=0 held for 20 cycles.
- `bin`=1234, one-cycle `start`: `done` exactly 16 cycles after the accepting edge, `bcd`=0x01234, `blank`=5'b10000, `busy` high 17 cycles.
- `bin`=65535: `bcd`=0x65535, `blank`=5'b00000. `bin`=0: `bcd`=0x00000, `blank`=5'b11110.
- Accept `bin`=42; pulse `start` with `bin`=999 at cycles 5 and 16: both ignored, result 0x00042. The first `start` in IDLE afterwards converts normally.
- Assert `reset` at cycle 8 of a conversion of 500: no `done`, outputs return to reset values, and a subsequent `start` with 77 yields 0x00077.
- `start` held high with `bin` stepping 9, 10, 99, 100 at each accept: `done` pulses 18 cycles apart with 0x00009, 0x00010, 0x00099, 0x00100.
